// File: rtl/vert_transform_if.sv
// Output stream of the vertex transformer: one screen-space vertex per transfer.
// Handshake: the producer raises out_valid with out_idx/out_x/out_y and holds
// all of them stable until a rising clk_pix edge samples out_valid && out_ready;
// that edge is the transfer, and out_valid never drops before it.
interface vert_transform_if #(
  parameter int IDX_W   = 2,
  parameter int COORD_W = 10
);
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_idx;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;

  modport master (
    output out_valid, out_idx, out_x, out_y,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_idx, out_x, out_y,
    output out_ready
  );
endinterface

// File: rtl/vert_transform.sv
// Rotates model vertices about the y axis by a free-running angle and maps them
// to screen coordinates. A frame_start pulse snapshots the angle for the pass,
// then every vertex goes FETCH -> CALC -> OUT, and DONE closes the pass.
module vert_transform #(
  parameter int  NVERT    = 3,
  parameter int  TRIG_W   = 12,
  parameter int  COORD_W  = 10,
  parameter int  TICK_DIV = 333334,
  parameter int  CX       = 320,
  parameter int  CY       = 240,
  localparam int IDX_W    = (NVERT > 1) ? $clog2(NVERT) : 1
) (
  input  logic                     clk_pix,
  input  logic                     resetn,
  input  logic                     frame_start,
  input  logic                     dir,
  input  logic                     pause,
  output logic [8:0]               angle,
  output logic [8:0]               trig_angle,
  input  logic signed [TRIG_W-1:0] cos,
  input  logic signed [TRIG_W-1:0] sin,
  output logic [IDX_W-1:0]         vert_idx,
  input  logic signed [7:0]        vx,
  input  logic signed [7:0]        vz,
  vert_transform_if.master         out_if,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CALC  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVERT - 1);

  // Product/sum width: 8 x TRIG_W product plus one bit for the sum, plus margin.
  localparam int PW = 8 + TRIG_W + 2;
  localparam int SW = ((PW > COORD_W) ? PW : COORD_W) + 2;
  localparam logic signed [SW-1:0] CX_S  = SW'(CX);
  localparam logic signed [SW-1:0] CY_S  = SW'(CY);
  localparam logic signed [SW-1:0] MAX_S = SW'((1 << COORD_W) - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [8:0]         angle_q, angle_d;
  logic [8:0]         trig_q;
  logic [IDX_W-1:0]   vidx_q;
  logic [IDX_W-1:0]   oidx_q;
  logic [COORD_W-1:0] ox_q, oy_q;
  logic               busy_q;
  logic               start_en_q;
  logic               start, calc_en, xfer;

  logic signed [PW-1:0]      vx_e, vz_e, cos_e, sin_e;
  logic signed [PW-1:0]      xsum, zsum, xr, zr;
  logic signed [SW-1:0]      sx, sy;
  logic [COORD_W-1:0]        sat_x, sat_y;

  // Clamp a signed screen coordinate into the unsigned output range.
  function automatic logic [COORD_W-1:0] clamp(input logic signed [SW-1:0] v);
    if (v < 0)
      return '0;
    else if (v > MAX_S)
      return MAX_S[COORD_W-1:0];
    else
      return v[COORD_W-1:0];
  endfunction

  // Angle divider next-state: hold on pause, step the angle on divider wrap.
  always_comb begin
    cnt_d   = cnt_q;
    angle_d = angle_q;
    if (!pause) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (dir)
          angle_d = (angle_q == 9'd0) ? 9'd359 : angle_q - 9'd1;
        else
          angle_d = (angle_q == 9'd359) ? 9'd0 : angle_q + 9'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Angle divider registers, independent of the transform FSM.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      angle_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      angle_q <= angle_d;
    end
  end

  // Blocks frame_start on the first edge after reset release.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) start_en_q <= 1'b0;
    else         start_en_q <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    calc_en = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start && start_en_q) begin
          start   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_CALC;
      S_CALC: begin
        calc_en = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_if.out_ready) begin
          xfer    = 1'b1;
          state_d = (vidx_q == LAST_IDX) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Rotation about y in full precision, then arithmetic shift back from Q1.10.
  always_comb begin
    vx_e  = {{(PW-8){vx[7]}}, vx};
    vz_e  = {{(PW-8){vz[7]}}, vz};
    cos_e = {{(PW-TRIG_W){cos[TRIG_W-1]}}, cos};
    sin_e = {{(PW-TRIG_W){sin[TRIG_W-1]}}, sin};
    xsum  = vx_e * cos_e - vz_e * sin_e;
    zsum  = vx_e * sin_e + vz_e * cos_e;
    xr    = xsum >>> 10;
    zr    = zsum >>> 10;
    sx    = CX_S + {{(SW-PW){xr[PW-1]}}, xr};
    sy    = CY_S + {{(SW-PW){zr[PW-1]}}, zr};
    sat_x = clamp(sx);
    sat_y = clamp(sy);
  end

  // Pass bookkeeping and the output holding registers.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      trig_q <= '0;
      vidx_q <= '0;
      oidx_q <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      if (start) begin
        trig_q <= angle_q;
        vidx_q <= '0;
        busy_q <= 1'b1;
      end
      if (calc_en) begin
        ox_q   <= sat_x;
        oy_q   <= sat_y;
        oidx_q <= vidx_q;
      end
      if (xfer && (vidx_q != LAST_IDX))
        vidx_q <= vidx_q + IDX_W'(1);
      if (state_q == S_DONE)
        busy_q <= 1'b0;
    end
  end

  assign angle            = angle_q;
  assign trig_angle       = trig_q;
  assign vert_idx         = vidx_q;
  assign busy             = busy_q;
  assign done             = (state_q == S_DONE);
  assign state_dbg        = state_q;
  assign out_if.out_valid = (state_q == S_OUT);
  assign out_if.out_idx   = oidx_q;
  assign out_if.out_x     = ox_q;
  assign out_if.out_y     = oy_q;

endmodule

// File: tb/tb_vert_transform.sv
// Bench for vert_transform: a main instance (NVERT=3, TICK_DIV=2) plus two
// NVERT=2 instances with CX=0 and CX=1000 for coordinate clamping.
module tb_vert_transform;

  logic clk;
  logic resetn;
  logic frame_start, frame_start_s;
  logic dir, pause;
  logic out_ready;
  logic signed [11:0] cos, sin;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic [8:0] angle_m, trig_m;
  logic [1:0] vidx_m;
  logic signed [7:0] vx_m, vz_m;
  logic busy_m, done_m;
  logic [2:0] state_m;
  logic signed [7:0] mem_vx[0:3];
  logic signed [7:0] mem_vz[0:3];

  vert_transform_if #(.IDX_W(2), .COORD_W(10)) oif ();
  assign oif.out_ready = out_ready;

  vert_transform #(.NVERT(3), .TICK_DIV(2)) dut (
    .clk_pix(clk), .resetn(resetn), .frame_start(frame_start), .dir(dir),
    .pause(pause), .angle(angle_m), .trig_angle(trig_m), .cos(cos), .sin(sin),
    .vert_idx(vidx_m), .vx(vx_m), .vz(vz_m), .out_if(oif), .busy(busy_m),
    .done(done_m), .state_dbg(state_m)
  );

  always @(posedge clk) begin
    vx_m <= mem_vx[vidx_m];
    vz_m <= mem_vz[vidx_m];
  end

  // ---------------- clamp instances ----------------
  logic [8:0] angle_s0, trig_s0, angle_s1, trig_s1;
  logic [0:0] vidx_s0, vidx_s1;
  logic signed [7:0] vx_s0, vx_s1;
  logic busy_s0, done_s0, busy_s1, done_s1;
  logic [2:0] state_s0, state_s1;
  logic signed [7:0] smem_vx[0:1];
  logic signed [7:0] zero8;
  assign zero8 = 8'sd0;

  vert_transform_if #(.IDX_W(1), .COORD_W(10)) sif0 ();
  vert_transform_if #(.IDX_W(1), .COORD_W(10)) sif1 ();
  assign sif0.out_ready = 1'b1;
  assign sif1.out_ready = 1'b1;

  vert_transform #(.NVERT(2), .CX(0)) dut_lo (
    .clk_pix(clk), .resetn(resetn), .frame_start(frame_start_s), .dir(dir),
    .pause(pause), .angle(angle_s0), .trig_angle(trig_s0), .cos(cos), .sin(sin),
    .vert_idx(vidx_s0), .vx(vx_s0), .vz(zero8), .out_if(sif0), .busy(busy_s0),
    .done(done_s0), .state_dbg(state_s0)
  );

  vert_transform #(.NVERT(2), .CX(1000)) dut_hi (
    .clk_pix(clk), .resetn(resetn), .frame_start(frame_start_s), .dir(dir),
    .pause(pause), .angle(angle_s1), .trig_angle(trig_s1), .cos(cos), .sin(sin),
    .vert_idx(vidx_s1), .vx(vx_s1), .vz(zero8), .out_if(sif1), .busy(busy_s1),
    .done(done_s1), .state_dbg(state_s1)
  );

  always @(posedge clk) begin
    vx_s0 <= smem_vx[vidx_s0];
    vx_s1 <= smem_vx[vidx_s1];
  end

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  logic [20:0] exp_lo_q[$];
  logic [20:0] exp_hi_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y);
    exp_q.push_back({idx, x, y});
  endtask

  // ---------------- monitors ----------------
  logic [21:0] out_vec, held_vec, exp_v;
  logic        stall_q = 1'b0;
  logic        gap_armed = 1'b0;
  int          gap = 0;
  assign out_vec = {oif.out_idx, oif.out_x, oif.out_y};

  always @(negedge clk) begin
    if (!resetn) begin
      stall_q   = 1'b0;
      gap_armed = 1'b0;
      gap       = 0;
    end else begin
      if (stall_q) begin
        check("stall_valid_held", 32'(oif.out_valid), 32'd1);
        check("stall_data_held", 32'(out_vec), 32'(held_vec));
      end
      if (gap_armed) begin
        gap++;
        if (oif.out_valid) begin
          check("next_vertex_latency", gap, 3);
          gap_armed = 1'b0;
        end
      end
      if (oif.out_valid && oif.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got idx %0d x %0d y %0d, none expected",
                   oif.out_idx, oif.out_x, oif.out_y);
        end else begin
          exp_v = exp_q.pop_front();
          check("out_idx", 32'(oif.out_idx), 32'(exp_v[21:20]));
          check("out_x", 32'(oif.out_x), 32'(exp_v[19:10]));
          check("out_y", 32'(oif.out_y), 32'(exp_v[9:0]));
        end
        if (oif.out_idx != 2'd2) begin
          gap_armed = 1'b1;
          gap       = 0;
        end
      end
      stall_q  = oif.out_valid && !oif.out_ready;
      held_vec = out_vec;
      if (done_m) done_cnt++;
    end
  end

  always @(negedge clk) begin
    if (resetn && sif0.out_valid && sif0.out_ready) begin
      if (exp_lo_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL clamp_lo_unexpected: got x %0d, none expected", sif0.out_x);
      end else
        check("clamp_lo_out", 32'({sif0.out_idx, sif0.out_x, sif0.out_y}), 32'(exp_lo_q.pop_front()));
    end
    if (resetn && sif1.out_valid && sif1.out_ready) begin
      if (exp_hi_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL clamp_hi_unexpected: got x %0d, none expected", sif1.out_x);
      end else
        check("clamp_hi_out", 32'({sif1.out_idx, sif1.out_x, sif1.out_y}), 32'(exp_hi_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_mem(input logic signed [7:0] x0, z0, x1, z1, x2, z2);
    mem_vx[0] = x0; mem_vz[0] = z0;
    mem_vx[1] = x1; mem_vz[1] = z1;
    mem_vx[2] = x2; mem_vz[2] = z2;
    mem_vx[3] = 8'sd0; mem_vz[3] = 8'sd0;
  endtask

  // Pulses frame_start and checks the first out_valid lands 3 cycles later.
  task automatic start_frame();
    int n;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    n = 1;
    while (!oif.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_valid_latency", n, 3);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done_m && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done_seen"}, 32'(done_m), 32'd1);
    @(posedge clk); #1;
    check({name, "_busy_low"}, 32'(busy_m), 32'd0);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int done_before;
    resetn = 1'b1; frame_start = 1'b0; frame_start_s = 1'b0;
    dir = 1'b1; pause = 1'b0; out_ready = 1'b1;
    cos = 12'sd1024; sin = 12'sd0;
    set_mem(8'sd100, 8'sd50, -8'sd128, 8'sd0, 8'sd0, -8'sd100);
    smem_vx[0] = -8'sd50; smem_vx[1] = 8'sd100;
    #1 resetn = 1'b0;
    #1;
    // reset state, no clock edge yet
    check("rst_angle", 32'(angle_m), 0);
    check("rst_trig_angle", 32'(trig_m), 0);
    check("rst_vert_idx", 32'(vidx_m), 0);
    check("rst_out_vec", 32'(out_vec), 0);
    check("rst_out_valid", 32'(oif.out_valid), 0);
    check("rst_busy_done", 32'({busy_m, done_m}), 0);
    check("rst_state", 32'(state_m), 0);

    // angle counter: TICK_DIV=2, decrement wraps 0 -> 359
    @(negedge clk) resetn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("angle_dec_wrap", 32'(angle_m), 359);
    dir = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("angle_inc_wrap", 32'(angle_m), 0);
    pause = 1'b1;
    repeat (10) begin @(posedge clk); #1; check("angle_paused", 32'(angle_m), 0); end
    pause = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    pause = 1'b1;
    check("angle_three_steps", 32'(angle_m), 3);

    // pass A: identity rotation
    cos = 12'sd1024; sin = 12'sd0;
    set_mem(8'sd100, 8'sd50, -8'sd128, 8'sd0, 8'sd0, -8'sd100);
    push(2'd0, 10'd420, 10'd290); push(2'd1, 10'd192, 10'd240); push(2'd2, 10'd320, 10'd140);
    start_frame();
    check("pass_a_trig_snapshot", 32'(trig_m), 3);
    check("pass_a_busy", 32'(busy_m), 1);
    wait_done("pass_a");

    // pass B: 90 degrees, plus a frame_start while busy that must be ignored
    cos = 12'sd0; sin = 12'sd1024;
    push(2'd0, 10'd270, 10'd340); push(2'd1, 10'd320, 10'd112); push(2'd2, 10'd420, 10'd240);
    start_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    wait_done("pass_b");
    repeat (6) begin @(posedge clk); #1; end
    check("busy_start_ignored", 32'(state_m), 0);

    // pass C: ~45 degrees, exercises truncation and arithmetic shift of negatives
    cos = 12'sd724; sin = 12'sd724;
    set_mem(8'sd100, 8'sd50, -8'sd100, 8'sd0, 8'sd0, 8'sd0);
    push(2'd0, 10'd355, 10'd346); push(2'd1, 10'd249, 10'd169); push(2'd2, 10'd320, 10'd240);
    start_frame();
    wait_done("pass_c");

    // pass D: 180 degrees with the angle running mid-pass
    cos = -12'sd1024; sin = 12'sd0;
    set_mem(-8'sd128, 8'sd0, 8'sd100, 8'sd50, 8'sd127, -8'sd128);
    push(2'd0, 10'd448, 10'd240); push(2'd1, 10'd220, 10'd190); push(2'd2, 10'd193, 10'd368);
    start_frame();
    pause = 1'b0;
    wait_done("pass_d");
    pause = 1'b1;
    check("trig_held_mid_pass", 32'(trig_m), 3);
    check("angle_moved_mid_pass", 32'(angle_m != 9'd3), 1);

    // pass E: back-pressure, vertex 1 stalled 5 cycles
    cos = 12'sd1024; sin = 12'sd0;
    set_mem(8'sd100, 8'sd50, -8'sd128, 8'sd0, 8'sd0, -8'sd100);
    push(2'd0, 10'd420, 10'd290); push(2'd1, 10'd192, 10'd240); push(2'd2, 10'd320, 10'd140);
    out_ready = 1'b0;
    start_frame();
    repeat (2) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n = 0;
    while (!oif.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    repeat (5) begin @(posedge clk); #1; end
    check("stall_v1_valid", 32'(oif.out_valid), 1);
    check("stall_v1_idx", 32'(oif.out_idx), 1);
    out_ready = 1'b1;
    wait_done("pass_e");
    check("done_pulses_so_far", done_cnt, 5);

    // clamp instances: CX=0 clamps low, CX=1000 clamps high
    exp_lo_q.push_back({1'b0, 10'd0, 10'd240});
    exp_lo_q.push_back({1'b1, 10'd100, 10'd240});
    exp_hi_q.push_back({1'b0, 10'd950, 10'd240});
    exp_hi_q.push_back({1'b1, 10'd1023, 10'd240});
    frame_start_s = 1'b1;
    @(posedge clk); #1;
    frame_start_s = 1'b0;
    n = 0;
    while (!done_s0 && n < 50) begin @(posedge clk); #1; n++; end
    check("clamp_done_seen", 32'({done_s0, done_s1}), 32'd3);
    @(posedge clk); #1;
    check("clamp_lo_drained", exp_lo_q.size(), 0);
    check("clamp_hi_drained", exp_hi_q.size(), 0);

    // reset in CALC of vertex 1 abandons the pass
    push(2'd0, 10'd420, 10'd290); push(2'd1, 10'd192, 10'd240); push(2'd2, 10'd320, 10'd140);
    start_frame();
    n = 0;
    while (!(state_m == 3'd2 && vidx_m == 2'd1) && n < 30) begin @(posedge clk); #1; n++; end
    check("reached_calc_v1", 32'({state_m, vidx_m}), 32'({3'd2, 2'd1}));
    done_before = done_cnt;
    #2 resetn = 1'b0;
    #1;
    check("async_rst_out_vec", 32'(out_vec), 0);
    check("async_rst_valid_busy_done", 32'({oif.out_valid, busy_m, done_m}), 0);
    check("async_rst_state_idx", 32'({state_m, vidx_m}), 0);
    check("async_rst_angles", 32'({angle_m, trig_m}), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    frame_start = 1'b1;
    push(2'd0, 10'd420, 10'd290); push(2'd1, 10'd192, 10'd240); push(2'd2, 10'd320, 10'd140);
    @(posedge clk); #1;
    check("start_ignored_first_edge", 32'(busy_m), 0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("start_taken_second_edge", 32'(busy_m), 1);
    check("no_done_after_reset", done_cnt, done_before);
    wait_done("restart");
    check("done_pulses_total", done_cnt, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
